// File: rtl/serial_alu_engine.sv
// Serial ALU engine: beat-serial operand load, one host op per cycle into acc (1-cycle latency), beat-serial drain.
// Drain holds out_data while out_ready is low; SERIAL_ALU_CHECKSUM_EN appends an XOR checksum beat after the result.
module serial_alu_engine #(
  parameter int DATA_W  = 64,
  parameter int BEAT_W  = 4,
  parameter int OPCNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BEAT_W-1:0]  in_a,
  input  logic [BEAT_W-1:0]  in_b,
  input  logic               op_valid,
  output logic               op_ready,
  input  logic [2:0]         op_code,
  input  logic               op_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BEAT_W-1:0]  out_data,
  output logic               out_last,
  output logic               busy,
  output logic [1:0]         state_o,
  output logic [OPCNT_W-1:0] op_count
);

  localparam int BEATS = DATA_W / BEAT_W;
  localparam int CNT_W = $clog2(BEATS);
`ifdef SERIAL_ALU_CHECKSUM_EN
  localparam int IDX_W    = CNT_W + 1;
  localparam int LAST_IDX = BEATS;
`else
  localparam int IDX_W    = CNT_W;
  localparam int LAST_IDX = BEATS - 1;
`endif

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam logic [DATA_W-1:0] LO_MASK = DATA_W'({(DATA_W/2){1'b1}});

  logic [1:0]         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]  a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [OPCNT_W-1:0] op_count_q, op_count_d;

  logic [DATA_W-1:0] and_ab, xor_ab, diff_ab, min_ab, max_ab, sat_ab, alu_res;
  logic [DATA_W:0]   sum_ab;
  logic              a_ge_b;
  logic [BEAT_W-1:0] beat;

  always_comb begin
    and_ab  = a_q & b_q;
    xor_ab  = a_q ^ b_q;
    a_ge_b  = (a_q >= b_q);
    diff_ab = a_ge_b ? (a_q - b_q) : (b_q - a_q);
    min_ab  = a_ge_b ? b_q : a_q;
    max_ab  = a_ge_b ? a_q : b_q;
    sum_ab  = {1'b0, a_q} + {1'b0, b_q};
    sat_ab  = sum_ab[DATA_W] ? '1 : sum_ab[DATA_W-1:0];
    case (op_code)
      3'd0:    alu_res = and_ab | acc_q;
      3'd1:    alu_res = xor_ab + acc_q;
      3'd2:    alu_res = diff_ab ^ acc_q;
      3'd3:    alu_res = (acc_q & ~LO_MASK) | (min_ab & LO_MASK);
      3'd4:    alu_res = max_ab + {acc_q[DATA_W-2:0], 1'b0};
      3'd5:    alu_res = sat_ab & acc_q;
      // Overflow-free floor average of A and B.
      3'd6:    alu_res = (and_ab + {1'b0, xor_ab[DATA_W-1:1]}) | acc_q;
      default: alu_res = {a_q[DATA_W-2:0], a_q[DATA_W-1]} ^ b_q ^ acc_q;
    endcase
  end

  always_comb begin
    beat = '0;
    for (int i = 0; i < BEATS; i++) begin
      if (idx_q == IDX_W'(i)) beat = acc_q[i*BEAT_W +: BEAT_W];
    end
`ifdef SERIAL_ALU_CHECKSUM_EN
    if (idx_q == IDX_W'(BEATS)) begin
      for (int i = 0; i < BEATS; i++) beat = beat ^ acc_q[i*BEAT_W +: BEAT_W];
    end
`endif
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    op_count_d = op_count_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_LOAD;
          idx_d      = '0;
          a_d        = '0;
          b_d        = '0;
          acc_d      = '0;
          op_count_d = '0;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          for (int i = 0; i < BEATS; i++) begin
            if (idx_q == IDX_W'(i)) begin
              a_d[i*BEAT_W +: BEAT_W] = in_a;
              b_d[i*BEAT_W +: BEAT_W] = in_b;
            end
          end
          if (idx_q == IDX_W'(BEATS-1)) begin
            idx_d   = '0;
            state_d = S_EXEC;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_EXEC: begin
        if (op_valid) begin
          acc_d = alu_res;
          if (op_count_q != '1) op_count_d = op_count_q + 1'b1;
          if (op_last) state_d = S_DRAIN;
        end
      end
      default: begin
        if (out_ready) begin
          if (idx_q == IDX_W'(LAST_IDX)) begin
            idx_d   = '0;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      op_count_q <= op_count_d;
    end
  end

  assign in_ready  = (state_q == S_LOAD);
  assign op_ready  = (state_q == S_EXEC);
  assign out_valid = (state_q == S_DRAIN);
  assign out_data  = out_valid ? beat : '0;
  assign out_last  = out_valid && (idx_q == IDX_W'(LAST_IDX));
  assign busy      = (state_q != S_IDLE);
  assign state_o   = state_q;
  assign op_count  = op_count_q;

endmodule
